// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcs4 (package)
// Description : Shared types for the MCS-4 bus monitor: instruction-cycle
//               subcycle encoding, address/character types and the fetch
//               record layout exposed on the host port.
// Revision    : 1.0 - initial release
// ============================================================================
package mcs4;

    typedef logic [11:0] addr_t;
    typedef logic [3:0]  char_t;

    // One state per subcycle of the 8-phase instruction cycle, plus the
    // idle state used until the first SYNC is seen.
    typedef enum logic [3:0] {
        UNLOCKED = 4'd0,
        A1       = 4'd1,
        A2       = 4'd2,
        A3       = 4'd3,
        M1       = 4'd4,
        M2       = 4'd5,
        X1       = 4'd6,
        X2       = 4'd7,
        X3       = 4'd8
    } subcycle_e;

    // Bit layout matches rec_data[23:0] from MSB to LSB.
    typedef struct packed {
        addr_t addr;
        char_t opr;
        char_t opa;
        char_t cm_ram_a3;
    } fetch_rec_t;

    localparam int c_rec_w = $bits(fetch_rec_t);

    // Free-running successor; X3 wraps to A1 whether or not SYNC was seen.
    function automatic subcycle_e next_subcycle(input subcycle_e s);
        subcycle_e n;
        case (s)
            A1:      n = A2;
            A2:      n = A3;
            A3:      n = M1;
            M1:      n = M2;
            M2:      n = X1;
            X1:      n = X2;
            X2:      n = X3;
            X3:      n = A1;
            default: n = UNLOCKED;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcs4_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_sync_fifo
// Description : Generic single-clock FIFO with a registered-storage head.
//               A push while full is accepted only if a pop happens in the
//               same cycle. The head output reads zero while empty.
// Ports       : clk, rst (async, active-high)
//               push, push_data, full   - write side
//               pop, valid, pop_data    - read side (pop ignored when empty)
//               level                   - entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_level = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;

    logic w_do_pop;
    logic w_do_push;

    assign valid     = (r_level != '0);
    assign full      = (r_level == c_full_level);
    assign w_do_pop  = pop & valid;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = push & (~full | w_do_pop);
    assign pop_data  = valid ? r_mem[r_rd_ptr] : '0;
    assign level     = r_level;

    // Storage is not reset; the cleared level makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcs4_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_bus_monitor
// Description : Passive MCS-4 bus observer. Tracks the 8-subcycle
//               instruction cycle from SYNC, captures ROM address, opcode
//               nibbles and the A3 CM-RAM lines of each fetch, and queues
//               one 24-bit record per fetch for a valid/ready host.
// Ports       : clk, rst (async, active-high)
//               clken_2            - phase-2 enable, sole bus sample point
//               sync, d_bus, cm_ram - MCS-4 bus (inputs only)
//               enable             - gates record pushes
//               rec_valid/rec_ready/rec_data - host drain port
//               fifo_level, overflow_cnt, sync_err, locked - status
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_bus_monitor
    import mcs4::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken_2,
    input  logic                          sync,
    input  logic [3:0]                    d_bus,
    input  logic [3:0]                    cm_ram,
    input  logic                          enable,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [23:0]                   rec_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt,
    output logic                          sync_err,
    output logic                          locked
);

    subcycle_e  r_state;
    subcycle_e  w_state_next;
    logic       w_sync_err_set;
    logic       w_rec_done;

    fetch_rec_t r_rec;
    logic       r_push_pend;
    logic       r_sync_err;
    logic [7:0] r_overflow_cnt;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_drop;
    logic [c_rec_w-1:0] w_head;

    // ------------------------------------------------------------------
    // Subcycle tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sync_err_set = 1'b0;
        w_rec_done     = 1'b0;
        if (clken_2) begin
            if (r_state == UNLOCKED) begin
                if (sync) w_state_next = A1;
            end else if (sync && (r_state != X3)) begin
                // Misplaced SYNC: realign and abandon the fetch in progress.
                w_state_next   = A1;
                w_sync_err_set = 1'b1;
            end else begin
                w_state_next = next_subcycle(r_state);
                w_rec_done   = (r_state == M2);
            end
        end
    end

    assign locked = (r_state != UNLOCKED);

    // ------------------------------------------------------------------
    // Field capture. Every field is rewritten before the next M2, so a
    // discarded partial record never leaks into a later push.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec <= '0;
        end else if (clken_2) begin
            case (r_state)
                A1: r_rec.addr[3:0]  <= d_bus;
                A2: r_rec.addr[7:4]  <= d_bus;
                A3: begin
                    r_rec.addr[11:8] <= d_bus;
                    r_rec.cm_ram_a3  <= cm_ram;
                end
                M1: r_rec.opr        <= d_bus;
                M2: r_rec.opa        <= d_bus;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Push stage, error flag and overflow accounting
    // ------------------------------------------------------------------
    // The push is pending for exactly one clk because clken_2 is never
    // asserted on consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push_pend    <= 1'b0;
            r_sync_err     <= 1'b0;
            r_overflow_cnt <= '0;
        end else begin
            r_push_pend <= w_rec_done;
            if (w_sync_err_set) r_sync_err <= 1'b1;
            if (w_drop && (r_overflow_cnt != 8'hFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 8'd1;
            end
        end
    end

    assign w_push       = r_push_pend & enable;
    assign w_pop        = rec_valid & rec_ready;
    assign w_drop       = w_push & w_full & ~w_pop;
    assign sync_err     = r_sync_err;
    assign overflow_cnt = r_overflow_cnt;
    assign rec_data     = w_head;

    mcs4_sync_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_rec),
        .full      (w_full),
        .pop       (w_pop),
        .valid     (rec_valid),
        .pop_data  (w_head),
        .level     (fifo_level)
    );

endmodule
`default_nettype wire
